// File: rtl/vga_band_scheduler_if.sv
// Config write port of vga_band_scheduler: valid/ready handshake with 2-bit address and 16-bit data.
interface vga_band_scheduler_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/vga_band_scheduler.sv
// Per-band RGB source selection with double-buffered config committed at each VS fall.
// Define VGA_BAND_TESTPATTERN_EN to make SEL code 3 produce colour bars instead of black.
module vga_band_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int LINE_W   = 10
) (
    input  logic                 iVGA_CLK,
    input  logic                 iRST_n,
    input  logic                 iBLANK_n,
    input  logic                 iVS,
    input  logic [23:0]          src0_rgb,
    input  logic [23:0]          src1_rgb,
    input  logic [23:0]          src2_rgb,
    vga_band_scheduler_if.slave  cfg,
    output logic [23:0]          oRGB,
    output logic [1:0]           oBAND,
    output logic                 oCOMMIT
);
    typedef enum logic {ST_RUN = 1'b0, ST_COMMIT = 1'b1} state_t;

    localparam logic [LINE_W-1:0] B1_DEF   = LINE_W'(160);
    localparam logic [LINE_W-1:0] B2_DEF   = LINE_W'(320);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACTIVE - 1);
    localparam logic [5:0]        SEL_DEF  = 6'b10_01_00;
    localparam int                BAR_W    = H_ACTIVE / 8;

    state_t            state_q, state_d;
    logic [LINE_W-1:0] pix_q, pix_d, line_q, line_d;
    logic              blank_prev_q, blank_prev_d, vs_prev_q, vs_prev_d, vs_fall_q, vs_fall_d;
    logic              ready_q, ready_d, dirty_q, dirty_d, commit_q, commit_d;
    logic [LINE_W-1:0] p_b1_q, p_b1_d, p_b2_q, p_b2_d, a_b1_q, a_b1_d, a_b2_q, a_b2_d;
    logic [5:0]        p_sel_q, p_sel_d, a_sel_q, a_sel_d;
    logic              p_ctrl_q, p_ctrl_d, a_ctrl_q, a_ctrl_d;
    logic [23:0]       rgb_q, rgb_d, fill_s;
    logic [1:0]        band_q, band_d, band_s, code_s;
    logic              wr_s;
    logic              unused_data_s;

    function automatic logic [1:0] band_of(input logic [LINE_W-1:0] ln,
                                           input logic [LINE_W-1:0] b1,
                                           input logic [LINE_W-1:0] b2);
        logic [1:0] b;
        if (ln < b1) begin
            b = 2'd0;
        end else if (ln < b2) begin
            b = 2'd1;
        end else begin
            b = 2'd2;
        end
        return b;
    endfunction

`ifdef VGA_BAND_TESTPATTERN_EN
    function automatic logic [23:0] bar_rgb(input logic [LINE_W-1:0] p);
        logic [LINE_W-1:0] bar;
        bar = p / LINE_W'(BAR_W);
        return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
    endfunction

    assign fill_s = bar_rgb(pix_q);
`else
    logic unused_pix_s;
    assign fill_s       = 24'h00_0000;
    assign unused_pix_s = ^{pix_q, BAR_W[0]};
`endif

    assign unused_data_s = ^cfg.cfg_data[15:LINE_W];
    assign cfg.cfg_ready = ready_q;
    assign oRGB          = rgb_q;
    assign oBAND         = band_q;
    assign oCOMMIT       = commit_q;

    // Next-state logic: counters, sync edge detect, config buffering, commit FSM, output mux.
    always_comb begin
        state_d      = state_q;
        pix_d        = iBLANK_n ? pix_q + LINE_W'(1) : '0;
        blank_prev_d = iBLANK_n;
        vs_prev_d    = iVS;
        vs_fall_d    = vs_prev_q & ~iVS;
        ready_d      = ready_q;
        dirty_d      = dirty_q;
        commit_d     = 1'b0;
        p_b1_d       = p_b1_q;
        p_b2_d       = p_b2_q;
        p_sel_d      = p_sel_q;
        p_ctrl_d     = p_ctrl_q;
        a_b1_d       = a_b1_q;
        a_b2_d       = a_b2_q;
        a_sel_d      = a_sel_q;
        a_ctrl_d     = a_ctrl_q;
        wr_s         = cfg.cfg_valid & ready_q;

        if (!iVS) begin
            line_d = '0;
        end else if (blank_prev_q && !iBLANK_n && (line_q < LINE_MAX)) begin
            line_d = line_q + LINE_W'(1);
        end else begin
            line_d = line_q;
        end

        if (wr_s) begin
            dirty_d = 1'b1;
            case (cfg.cfg_addr)
                2'd0:    p_b1_d   = cfg.cfg_data[LINE_W-1:0];
                2'd1:    p_b2_d   = cfg.cfg_data[LINE_W-1:0];
                2'd2:    p_sel_d  = cfg.cfg_data[5:0];
                default: p_ctrl_d = cfg.cfg_data[0];
            endcase
        end else begin
            dirty_d = dirty_q;
        end

        case (state_q)
            ST_RUN: begin
                if (vs_fall_q) begin
                    state_d = ST_COMMIT;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
                ready_d = 1'b1;
                dirty_d = 1'b0;
                if (dirty_q) begin
                    a_b1_d   = p_b1_q;
                    a_b2_d   = p_b2_q;
                    a_sel_d  = p_sel_q;
                    a_ctrl_d = p_ctrl_q;
                    commit_d = 1'b1;
                end else begin
                    commit_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
                ready_d = 1'b0;
            end
        endcase

        band_s = band_of(line_q, a_b1_q, a_b2_q);
        case (band_s)
            2'd0:    code_s = a_sel_q[1:0];
            2'd1:    code_s = a_sel_q[3:2];
            default: code_s = a_sel_q[5:4];
        endcase
        band_d = band_s;

        if (!iBLANK_n || a_ctrl_q) begin
            rgb_d = 24'h00_0000;
        end else begin
            case (code_s)
                2'd0:    rgb_d = src0_rgb;
                2'd1:    rgb_d = src1_rgb;
                2'd2:    rgb_d = src2_rgb;
                default: rgb_d = fill_s;
            endcase
        end
    end

    // State registers; reset aborts the frame and restores the default config in both buffers.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= ST_RUN;
            pix_q        <= '0;
            line_q       <= '0;
            blank_prev_q <= 1'b0;
            vs_prev_q    <= 1'b1;
            vs_fall_q    <= 1'b0;
            ready_q      <= 1'b0;
            dirty_q      <= 1'b0;
            commit_q     <= 1'b0;
            p_b1_q       <= B1_DEF;
            p_b2_q       <= B2_DEF;
            p_sel_q      <= SEL_DEF;
            p_ctrl_q     <= 1'b0;
            a_b1_q       <= B1_DEF;
            a_b2_q       <= B2_DEF;
            a_sel_q      <= SEL_DEF;
            a_ctrl_q     <= 1'b0;
            rgb_q        <= 24'h00_0000;
            band_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
            blank_prev_q <= blank_prev_d;
            vs_prev_q    <= vs_prev_d;
            vs_fall_q    <= vs_fall_d;
            ready_q      <= ready_d;
            dirty_q      <= dirty_d;
            commit_q     <= commit_d;
            p_b1_q       <= p_b1_d;
            p_b2_q       <= p_b2_d;
            p_sel_q      <= p_sel_d;
            p_ctrl_q     <= p_ctrl_d;
            a_b1_q       <= a_b1_d;
            a_b2_q       <= a_b2_d;
            a_sel_q      <= a_sel_d;
            a_ctrl_q     <= a_ctrl_d;
            rgb_q        <= rgb_d;
            band_q       <= band_d;
        end
    end
endmodule

// File: tb/tb_vga_band_scheduler.sv
// Bench for vga_band_scheduler: short lines (ACT pixels each) with full 480-line frames,
// a table of config scenarios with probe lines, and randomized writes/sources against a frame-level model.
module tb_vga_band_scheduler;
    localparam int ACT = 4;
    localparam int BLK = 2;
    localparam int VA  = 480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blank_n = 1'b0;
    logic        vs = 1'b1;
    logic [23:0] s0 = 24'hFF0000, s1 = 24'h00FF00, s2 = 24'h0000FF;
    logic [23:0] rgb;
    logic [1:0]  band;
    logic        commit;

    vga_band_scheduler_if cfg_if();

    vga_band_scheduler dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .iBLANK_n (blank_n),
        .iVS      (vs),
        .src0_rgb (s0),
        .src1_rgb (s1),
        .src2_rgb (s2),
        .cfg      (cfg_if),
        .oRGB     (rgb),
        .oBAND    (band),
        .oCOMMIT  (commit)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: pending/active config as seen by the frame rules.
    int p_b1, p_b2, p_sel, p_ctrl, a_b1, a_b2, a_sel, a_ctrl;
    bit dirty, vs_last, fresh, rand_src;
    int vs_age;
    int ready_lows, commits;

    typedef struct packed {
        logic [1:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t wq[$];

    typedef struct packed {
        logic [15:0] b1, b2;
        logic [5:0]  sel;
        logic        ctrl;
        logic [9:0]  l0, l1, l2;
        logic [1:0]  e0, e1, e2;
        logic [23:0] r0, r1, r2;
    } vec_t;
    vec_t vt[7];

    logic [1:0]  obs_band[VA];
    logic [23:0] obs_rgb[VA];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        p_b1 = 160; p_b2 = 320; p_sel = 36; p_ctrl = 0;
        a_b1 = 160; a_b2 = 320; a_sel = 36; a_ctrl = 0;
        dirty = 1'b0; vs_last = 1'b1; fresh = 1'b1; vs_age = 100;
        wq.delete();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_data  = 16'd0;
    endtask

    function automatic logic [23:0] exp_rgb(input bit b, input int line);
        int bd, code;
        if (!b || a_ctrl != 0) return 24'h0;
        bd   = (line < a_b1) ? 0 : (line < a_b2) ? 1 : 2;
        code = (a_sel >> (2 * bd)) % 4;
        case (code)
            0:       return s0;
            1:       return s1;
            2:       return s2;
            default: return 24'h0;
        endcase
    endfunction

    // One pixel clock: drive inputs, predict, advance, compare.
    task automatic step(input bit b, input bit v, input int line);
        int band_e;
        logic [23:0] rgb_e;
        bit ready_e, acc, cmt_e;
        blank_n = b;
        vs = v;
        if (rand_src) begin
            s0 = 24'($urandom); s1 = 24'($urandom); s2 = 24'($urandom);
        end
        if (vs_last && !v) vs_age = 0;
        else if (vs_age < 100) vs_age++;
        vs_last = v;
        ready_e = !fresh && (vs_age != 2);
        fresh = 1'b0;
        chk("cfg_ready", {31'd0, cfg_if.cfg_ready}, {31'd0, ready_e});
        if (!cfg_if.cfg_ready) ready_lows++;
        cfg_if.cfg_valid = (wq.size() > 0);
        if (wq.size() > 0) begin
            cfg_if.cfg_addr = wq[0].addr;
            cfg_if.cfg_data = wq[0].data;
        end
        acc    = (wq.size() > 0) && ready_e;
        band_e = (line < a_b1) ? 0 : (line < a_b2) ? 1 : 2;
        rgb_e  = exp_rgb(b, line);
        cmt_e  = (vs_age == 2) && dirty;
        if (vs_age == 2) begin
            if (dirty) begin
                a_b1 = p_b1; a_b2 = p_b2; a_sel = p_sel; a_ctrl = p_ctrl;
            end
            dirty = 1'b0;
        end
        if (acc) begin
            case (wq[0].addr)
                2'd0:    p_b1   = int'(wq[0].data) % 1024;
                2'd1:    p_b2   = int'(wq[0].data) % 1024;
                2'd2:    p_sel  = int'(wq[0].data) % 64;
                default: p_ctrl = int'(wq[0].data) % 2;
            endcase
            dirty = 1'b1;
            void'(wq.pop_front());
        end
        @(posedge clk);
        #1;
        chk("oRGB", {8'd0, rgb}, {8'd0, rgb_e});
        if (b) chk("oBAND", {30'd0, band}, 32'(band_e));
        chk("oCOMMIT", {31'd0, commit}, {31'd0, cmt_e});
        if (commit) commits++;
        if (b && line >= 0 && line < VA) begin
            obs_band[line] = band;
            obs_rgb[line]  = rgb;
        end
        cfg_if.cfg_valid = (wq.size() > 0);
    endtask

    task automatic push_vec(input vec_t v);
        wq.push_back('{2'd0, v.b1});
        wq.push_back('{2'd1, v.b2});
        wq.push_back('{2'd2, {10'd0, v.sel}});
        wq.push_back('{2'd3, {15'd0, v.ctrl}});
    endtask

    // Vertical blank with a 3-cycle VS pulse; optionally queue writes at the VS fall.
    task automatic vsync(input bit push_at_fall);
        for (int i = 0; i < 12; i++) begin
            if (push_at_fall && i == 3) begin
                wq.push_back('{2'd2, 16'h0024});
                wq.push_back('{2'd3, 16'h0000});
                wq.push_back('{2'd0, 16'd300});
                wq.push_back('{2'd1, 16'd200});
            end
            step(1'b0, !(i >= 3 && i < 6), -1);
        end
    endtask

    task automatic lines(input int n, input int push_idx, input bit rnd);
        wr_t w;
        for (int l = 0; l < n; l++) begin
            if (l == 240 && push_idx >= 0) push_vec(vt[push_idx]);
            if (rnd && $urandom_range(0, 7) == 0) begin
                w.addr = 2'($urandom_range(0, 3));
                w.data = 16'($urandom) & 16'hFC00;
                if (w.addr < 2'd2) w.data = w.data | 16'($urandom_range(0, 130));
                else if (w.addr == 2'd2) w.data = 16'($urandom);
                else w.data = w.data | 16'($urandom_range(0, 3) == 0);
                wq.push_back(w);
            end
            for (int p = 0; p < ACT; p++) step(1'b1, 1'b1, l);
            for (int p = 0; p < BLK; p++) step(1'b0, 1'b1, l);
        end
    endtask

    task automatic probe(input vec_t v, input int t);
        chk($sformatf("band[%0d] L%0d", t, v.l0), {30'd0, obs_band[v.l0]}, {30'd0, v.e0});
        chk($sformatf("band[%0d] L%0d", t, v.l1), {30'd0, obs_band[v.l1]}, {30'd0, v.e1});
        chk($sformatf("band[%0d] L%0d", t, v.l2), {30'd0, obs_band[v.l2]}, {30'd0, v.e2});
        chk($sformatf("rgb[%0d] L%0d", t, v.l0), {8'd0, obs_rgb[v.l0]}, {8'd0, v.r0});
        chk($sformatf("rgb[%0d] L%0d", t, v.l1), {8'd0, obs_rgb[v.l1]}, {8'd0, v.r1});
        chk($sformatf("rgb[%0d] L%0d", t, v.l2), {8'd0, obs_rgb[v.l2]}, {8'd0, v.r2});
    endtask

    initial begin
        vt[0] = '{16'd160, 16'd320, 6'h24, 1'b0, 10'd159, 10'd160, 10'd320, 2'd0, 2'd1, 2'd2,
                  24'hFF0000, 24'h00FF00, 24'h0000FF};
        vt[1] = '{16'd100, 16'd200, 6'h24, 1'b0, 10'd99, 10'd100, 10'd200, 2'd0, 2'd1, 2'd2,
                  24'hFF0000, 24'h00FF00, 24'h0000FF};
        vt[2] = '{16'd100, 16'd200, 6'h00, 1'b0, 10'd0, 10'd150, 10'd479, 2'd0, 2'd1, 2'd2,
                  24'hFF0000, 24'hFF0000, 24'hFF0000};
        vt[3] = '{16'd100, 16'd200, 6'h2C, 1'b0, 10'd50, 10'd150, 10'd300, 2'd0, 2'd1, 2'd2,
                  24'hFF0000, 24'h000000, 24'h0000FF};
        vt[4] = '{16'd300, 16'd200, 6'h24, 1'b0, 10'd199, 10'd299, 10'd300, 2'd0, 2'd0, 2'd2,
                  24'hFF0000, 24'hFF0000, 24'h0000FF};
        vt[5] = '{16'd500, 16'd600, 6'h24, 1'b0, 10'd0, 10'd300, 10'd479, 2'd0, 2'd0, 2'd0,
                  24'hFF0000, 24'hFF0000, 24'hFF0000};
        vt[6] = '{16'd160, 16'd320, 6'h24, 1'b1, 10'd0, 10'd200, 10'd479, 2'd0, 2'd1, 2'd2,
                  24'h000000, 24'h000000, 24'h000000};

        rand_src = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset oRGB", {8'd0, rgb}, 32'd0);
        chk("reset oBAND", {30'd0, band}, 32'd0);
        chk("reset oCOMMIT", {31'd0, commit}, 32'd0);
        chk("reset cfg_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
        rst_n = 1'b1;

        // Table: frame t shows vt[t]; vt[t+1] is written mid-frame and must not show until the next VS.
        for (int t = 0; t < 7; t++) begin
            commits = 0;
            vsync(1'b0);
            lines(VA, (t < 6) ? t + 1 : -1, 1'b0);
            chk($sformatf("commit count frame %0d", t), 32'(commits), (t == 0) ? 32'd0 : 32'd1);
            probe(vt[t], t);
        end

        // Reset mid-line 250 with a pending write: defaults back, no commit at the next VS.
        vsync(1'b0);
        wq.push_back('{2'd0, 16'd50});
        lines(250, -1, 1'b0);
        step(1'b1, 1'b1, 250);
        step(1'b1, 1'b1, 250);
        rst_n = 1'b0;
        #1;
        chk("async reset oRGB", {8'd0, rgb}, 32'd0);
        chk("async reset cfg_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        commits = 0;
        vsync(1'b0);
        lines(VA, -1, 1'b0);
        chk("no commit after reset", 32'(commits), 32'd0);
        probe(vt[0], 7);

        // Writes held across the commit cycle: one stall cycle, B1/B2 land a frame later.
        ready_lows = 0;
        commits = 0;
        vsync(1'b1);
        chk("ready low cycles", 32'(ready_lows), 32'd1);
        chk("commit with partial writes", 32'(commits), 32'd1);
        lines(VA, -1, 1'b0);
        probe(vt[0], 8);
        commits = 0;
        vsync(1'b0);
        chk("commit of stalled writes", 32'(commits), 32'd1);
        lines(VA, -1, 1'b0);
        probe(vt[4], 9);

        // Randomized sources, writes and frame heights against the model.
        rand_src = 1'b1;
        for (int f = 0; f < 8; f++) begin
            vsync(1'b0);
            lines($urandom_range(40, 140), -1, 1'b1);
        end
        wq.delete();
        vsync(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
